// File: rtl/rect_frame_scheduler.sv
// rect_frame_scheduler
// Shares one rectangle-counting engine between N_SRC pixel sources. Whole
// frames are granted round-robin; the owner's pixel stream is forwarded to
// the engine, and the engine result comes back on a valid/ready port tagged
// with the owning source.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   src_req[N]         source i has a frame ready
//   src_valid[N]       per-source pixel beat valid
//   src_pixel[N]       per-source pixel value
//   src_ready[N]       beat accepted (owner only, STREAM only)
//   gnt[N]             current frame owner, one-hot or zero
//   eng_start_frame    one-cycle frame start to engine
//   eng_vld/eng_pixel  pixel beat to engine
//   eng_done           engine frame-complete pulse
//   eng_count          engine result, valid with eng_done
//   res_valid/ready    result handshake
//   res_src            source ID of the result
//   res_count          rectangle count (0 on timeout)
//   res_err            engine did not answer in time
//
// state     | meaning
// IDLE      | arbitrate among requesting sources
// START     | pulse eng_start_frame, clear beat counter
// STREAM    | forward owner beats until the frame's last beat
// WAIT_DONE | wait for eng_done, bounded by the timeout down-counter
// RESULT    | hold result until consumer accepts it
module rect_frame_scheduler #(
    parameter int N_SRC   = 4,
    parameter int COLS    = 1024,
    parameter int ROWS    = 512,
    parameter int CNT_W   = 17,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SRC-1:0]           src_req,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [N_SRC-1:0]           src_pixel,
    output logic [N_SRC-1:0]           src_ready,
    output logic [N_SRC-1:0]           gnt,
    output logic                       eng_start_frame,
    output logic                       eng_vld,
    output logic                       eng_pixel,
    input  logic                       eng_done,
    input  logic [CNT_W-1:0]           eng_count,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(N_SRC)-1:0]   res_src,
    output logic [CNT_W-1:0]           res_count,
    output logic                       res_err
);

    localparam int SRC_W  = $clog2(N_SRC);
    localparam int BEATS  = COLS * ROWS;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, START, STREAM, WAIT_DONE, RESULT} state_t;

    state_t              state_q, state_d;
    logic [SRC_W-1:0]    owner_q, rr_ptr_q;
    logic [SRC_W-1:0]    pick_idx, cand;
    logic                pick_found;
    logic [N_SRC-1:0]    pick_oh;
    logic [N_SRC-1:0]    gnt_q;
    logic                start_q;
    logic                pix_last_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [TMR_W-1:0]    tmr_q;
    logic                beat_acc;
    logic                res_valid_q;
    logic [SRC_W-1:0]    res_src_q;
    logic [CNT_W-1:0]    res_count_q;
    logic                res_err_q;

    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_SRC) sum = sum - N_SRC;
        return SRC_W'(sum);
    endfunction

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        pick_oh    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cand = wrap_add(rr_ptr_q, i);
            if (!pick_found && src_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_oh[pick_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state plus the zero-latency stream path to the engine. On stall
    // cycles eng_pixel shows the last forwarded value rather than the owner's
    // current (invalid) pixel.
    always_comb begin
        state_d   = state_q;
        beat_acc  = 1'b0;
        src_ready = '0;
        eng_vld   = 1'b0;
        eng_pixel = pix_last_q;
        case (state_q)
            IDLE: begin
                if (pick_found) state_d = START;
            end
            START: begin
                state_d = STREAM;
            end
            STREAM: begin
                src_ready = gnt_q;
                if (src_valid[owner_q]) begin
                    eng_vld   = 1'b1;
                    eng_pixel = src_pixel[owner_q];
                    beat_acc  = 1'b1;
                    if (beat_q == LAST_BEAT) state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (eng_done || (tmr_q == '0)) state_d = RESULT;
            end
            RESULT: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            start_q     <= 1'b0;
            pix_last_q  <= 1'b0;
            beat_q      <= '0;
            tmr_q       <= '0;
            res_valid_q <= 1'b0;
            res_src_q   <= '0;
            res_count_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        owner_q <= pick_idx;
                        gnt_q   <= pick_oh;
                        start_q <= 1'b1;
                    end
                end
                START: begin
                    beat_q <= '0;
                end
                STREAM: begin
                    // Reloaded every stream cycle so WAIT_DONE starts full.
                    tmr_q <= TMR_LOAD;
                    if (beat_acc) begin
                        pix_last_q <= src_pixel[owner_q];
                        if (beat_q != LAST_BEAT) beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    // eng_done is checked first so it wins over a
                    // simultaneous terminal count.
                    if (eng_done) begin
                        res_valid_q <= 1'b1;
                        res_src_q   <= owner_q;
                        res_count_q <= eng_count;
                        res_err_q   <= 1'b0;
                    end else if (tmr_q == '0) begin
                        res_valid_q <= 1'b1;
                        res_src_q   <= owner_q;
                        res_count_q <= '0;
                        res_err_q   <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        gnt_q       <= '0;
                        rr_ptr_q    <= wrap_add(owner_q, 1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt             = gnt_q;
    assign eng_start_frame = start_q;
    assign res_valid       = res_valid_q;
    assign res_src         = res_src_q;
    assign res_count       = res_count_q;
    assign res_err         = res_err_q;

endmodule

// File: tb/tb_rect_frame_scheduler.sv
// Bench for rect_frame_scheduler with an 8x4 frame, 4 sources, timeout 16.
// A frame-level model follows each frame through arbitration, streaming,
// engine wait and result handshake, and is checked every cycle on the
// falling edge; directed scenarios add literal expectations on top.
module tb_rect_frame_scheduler;
    localparam int N_SRC   = 4;
    localparam int COLS    = 8;
    localparam int ROWS    = 4;
    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 16;
    localparam int SRC_W   = 2;
    localparam int BEATS   = COLS * ROWS;

    logic                clk;
    logic                rst_n;
    logic [N_SRC-1:0]    src_req, src_valid, src_pixel, src_ready, gnt;
    logic                eng_start_frame, eng_vld, eng_pixel, eng_done;
    logic [CNT_W-1:0]    eng_count;
    logic                res_valid, res_ready, res_err;
    logic [SRC_W-1:0]    res_src;
    logic [CNT_W-1:0]    res_count;

    rect_frame_scheduler #(
        .N_SRC(N_SRC), .COLS(COLS), .ROWS(ROWS), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_req(src_req), .src_valid(src_valid), .src_pixel(src_pixel),
        .src_ready(src_ready), .gnt(gnt),
        .eng_start_frame(eng_start_frame), .eng_vld(eng_vld), .eng_pixel(eng_pixel),
        .eng_done(eng_done), .eng_count(eng_count),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_src(res_src), .res_count(res_count), .res_err(res_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus configuration, latched per frame by engine and model
    int               cfg_delay;   // 0 = engine never answers
    int               cfg_ret;
    logic             cfg_stray;
    logic [N_SRC-1:0] tog_mask;

    // model state
    int               cyc, m_phase, m_owner, m_rr, m_beats, m_delay, m_ret;
    int               m_exp_cnt, m_exp_err, m_res_cyc, m_last_cyc;
    logic             m_last_pix;
    int               frames_started, results_seen, n_vld_frame, n_start, n_stall;
    int               last_res_lat;
    logic [N_SRC-1:0] gnt_log[$];
    logic [CNT_W-1:0] hs_count;
    logic             hs_err;
    logic [SRC_W-1:0] hs_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N_SRC-1:0] oh(input int i);
        return N_SRC'(1) << i;
    endfunction

    function automatic int rr_pick(input logic [N_SRC-1:0] req, input int ptr);
        for (int k = 0; k < N_SRC; k++)
            if (req[(ptr + k) % N_SRC]) return (ptr + k) % N_SRC;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_starts(input int target);
        int n = 0;
        while (frames_started < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_start", 32'(frames_started >= target), 1);
    endtask

    task automatic wait_results(input int target);
        int n = 0;
        while (results_seen < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_result", 32'(results_seen >= target), 1);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_gnt"}, gnt, 0);
        chk({p, "_src_ready"}, src_ready, 0);
        chk({p, "_start"}, eng_start_frame, 0);
        chk({p, "_eng_vld"}, eng_vld, 0);
        chk({p, "_eng_pixel"}, eng_pixel, 0);
        chk({p, "_res_valid"}, res_valid, 0);
        chk({p, "_res_src"}, res_src, 0);
        chk({p, "_res_count"}, res_count, 0);
        chk({p, "_res_err"}, res_err, 0);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // sources: owner bits in tog_mask toggle valid every cycle, others always valid
    initial begin
        logic tog;
        tog = 1'b0;
        src_valid = '0;
        src_pixel = '0;
        forever begin
            step();
            for (int i = 0; i < N_SRC; i++) begin
                src_valid[i] = tog_mask[i] ? tog : 1'b1;
                src_pixel[i] = 1'($urandom_range(0, 1));
            end
            tog = ~tog;
        end
    end

    // engine: done 'delay' cycles after the last beat; optional stray early pulse
    initial begin
        int e_beats, e_wait, e_delay, e_ret;
        logic e_stray;
        eng_done = 1'b0;
        eng_count = '0;
        e_beats = 0; e_wait = 0; e_delay = 0; e_ret = 0; e_stray = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                e_beats = 0; e_wait = 0; e_stray = 1'b0;
            end else begin
                if (eng_start_frame) begin
                    e_beats = 0; e_delay = cfg_delay; e_ret = cfg_ret; e_stray = cfg_stray;
                end
                if (eng_vld) begin
                    e_beats++;
                    if (e_beats == BEATS) e_wait = e_delay;
                end
            end
            step();
            eng_done = 1'b0;
            if (e_stray) begin
                eng_done = 1'b1;
                eng_count = '1;
                e_stray = 1'b0;
            end else if (e_wait == 1) begin
                eng_done = 1'b1;
                eng_count = CNT_W'(e_ret);
                e_wait = 0;
            end else if (e_wait > 1) begin
                e_wait--;
            end
        end
    end

    // frame-level model and per-cycle compare
    initial begin
        int w;
        cyc = 0; m_phase = 0; m_rr = 0; m_owner = 0; m_beats = 0; m_last_pix = 1'b0;
        m_delay = 0; m_ret = 0; m_exp_cnt = 0; m_exp_err = 0; m_res_cyc = 0; m_last_cyc = 0;
        frames_started = 0; results_seen = 0; n_vld_frame = 0; n_start = 0; n_stall = 0;
        last_res_lat = 0; hs_count = '0; hs_err = 1'b0; hs_src = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_phase = 0; m_rr = 0; m_beats = 0; m_last_pix = 1'b0;
                chk("rst_gnt", gnt, 0);
                chk("rst_res_valid", res_valid, 0);
            end else begin
                if (eng_start_frame) begin n_start++; n_vld_frame = 0; end
                if (eng_vld) n_vld_frame++;
                if (m_phase == 3 && cyc == m_res_cyc) m_phase = 4;
                case (m_phase)
                    0: begin
                        chk("idle_gnt", gnt, 0);
                        chk("idle_start", eng_start_frame, 0);
                        chk("idle_ready", src_ready, 0);
                        chk("idle_vld", eng_vld, 0);
                        chk("idle_res_valid", res_valid, 0);
                        w = rr_pick(src_req, m_rr);
                        if (w >= 0) begin m_owner = w; m_phase = 1; end
                    end
                    1: begin
                        chk("start_pulse", eng_start_frame, 1);
                        chk("start_gnt", gnt, oh(m_owner));
                        chk("start_ready", src_ready, 0);
                        chk("start_vld", eng_vld, 0);
                        chk("start_res_valid", res_valid, 0);
                        m_delay = cfg_delay; m_ret = cfg_ret; m_beats = 0;
                        frames_started++;
                        gnt_log.push_back(gnt);
                        m_phase = 2;
                    end
                    2: begin
                        chk("stream_start", eng_start_frame, 0);
                        chk("stream_gnt", gnt, oh(m_owner));
                        chk("stream_ready", src_ready, oh(m_owner));
                        chk("stream_vld", eng_vld, src_valid[m_owner]);
                        chk("stream_res_valid", res_valid, 0);
                        if (src_valid[m_owner]) begin
                            chk("pix_fwd", eng_pixel, src_pixel[m_owner]);
                            m_last_pix = src_pixel[m_owner];
                            m_beats++;
                            if (m_beats == BEATS) begin
                                m_last_cyc = cyc;
                                if (m_delay >= 1 && m_delay <= TIMEOUT) begin
                                    m_res_cyc = cyc + m_delay + 1;
                                    m_exp_cnt = m_ret; m_exp_err = 0;
                                end else begin
                                    m_res_cyc = cyc + TIMEOUT + 1;
                                    m_exp_cnt = 0; m_exp_err = 1;
                                end
                                m_phase = 3;
                            end
                        end else begin
                            chk("pix_hold", eng_pixel, m_last_pix);
                            n_stall++;
                        end
                    end
                    3: begin
                        chk("wait_gnt", gnt, oh(m_owner));
                        chk("wait_ready", src_ready, 0);
                        chk("wait_vld", eng_vld, 0);
                        chk("wait_res_valid", res_valid, 0);
                    end
                    default: begin
                        chk("res_valid", res_valid, 1);
                        chk("res_src", res_src, m_owner);
                        chk("res_count", res_count, m_exp_cnt);
                        chk("res_err", res_err, m_exp_err);
                        chk("res_gnt", gnt, oh(m_owner));
                        chk("res_ready_out", src_ready, 0);
                        chk("res_vld", eng_vld, 0);
                        if (cyc == m_res_cyc) last_res_lat = cyc - m_last_cyc;
                        if (res_ready) begin
                            hs_count = res_count; hs_err = res_err; hs_src = res_src;
                            results_seen++;
                            m_rr = (m_owner + 1) % N_SRC;
                            m_phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        logic [N_SRC-1:0] exp_order [8];
        int base, r0, stall0, n;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rst_n = 1'b0; src_req = '0; res_ready = 1'b1;
        cfg_delay = 1; cfg_ret = 5; cfg_stray = 1'b0; tog_mask = '0;
        repeat (3) @(posedge clk);
        #3;
        chk_zero("reset");
        step();
        rst_n = 1'b1;

        // all sources request continuously: 8 frames round robin from 0
        step(); src_req = '1;
        wait_starts(8);
        step(); src_req = '0;
        wait_results(8);
        chk("order_len", gnt_log.size(), 8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("order", gnt_log[i], exp_order[i]);

        // single source 0, engine returns 3 one cycle after last beat
        cfg_ret = 3; cfg_delay = 1; base = n_start;
        step(); src_req = 4'b0001;
        wait_starts(9);
        step(); src_req = '0;
        wait_results(9);
        chk("t1_src", hs_src, 0);
        chk("t1_count", hs_count, 3);
        chk("t1_err", hs_err, 0);
        chk("t1_beats", n_vld_frame, 32);
        chk("t1_starts", n_start - base, 1);
        chk("t1_latency", last_res_lat, 2);

        // owner (2) valid 50%, others always valid, stray early done ignored
        cfg_ret = 6; cfg_delay = 2; cfg_stray = 1'b1; stall0 = n_stall;
        step(); tog_mask = 4'b0100; src_req = 4'b0100;
        wait_starts(10);
        step(); src_req = '0;
        wait_results(10);
        tog_mask = '0; cfg_stray = 1'b0;
        chk("t3_src", hs_src, 2);
        chk("t3_count", hs_count, 6);
        chk("t3_err", hs_err, 0);
        chk("t3_beats", n_vld_frame, 32);
        chk("t3_stalls", 32'(n_stall > stall0), 1);
        chk("t3_latency", last_res_lat, 3);

        // engine never answers: timeout
        cfg_delay = 0; cfg_ret = 5;
        step(); src_req = 4'b0010;
        wait_starts(11);
        step(); src_req = '0;
        wait_results(11);
        chk("to_src", hs_src, 1);
        chk("to_count", hs_count, 0);
        chk("to_err", hs_err, 1);
        chk("to_latency", last_res_lat, 17);

        // done on the very cycle the timeout expires: done wins
        cfg_delay = 16; cfg_ret = 7;
        step(); src_req = 4'b0010;
        wait_starts(12);
        step(); src_req = '0;
        wait_results(12);
        chk("edge_count", hs_count, 7);
        chk("edge_err", hs_err, 0);
        chk("edge_latency", last_res_lat, 17);

        // done one cycle too late: timeout
        cfg_delay = 17; cfg_ret = 4;
        step(); src_req = 4'b1000;
        wait_starts(13);
        step(); src_req = '0;
        wait_results(13);
        chk("late_src", hs_src, 3);
        chk("late_count", hs_count, 0);
        chk("late_err", hs_err, 1);

        // result back-pressure for 20 cycles with everyone requesting
        cfg_delay = 1; cfg_ret = 2;
        step(); res_ready = 1'b0; src_req = 4'b0001;
        wait_starts(14);
        step(); src_req = '1;
        n = 0;
        while (m_phase != 4 && n < 200) begin @(negedge clk); n++; end
        chk("bp_reached", 32'(m_phase == 4), 1);
        repeat (20) @(negedge clk);
        chk("bp_valid", res_valid, 1);
        chk("bp_gnt", gnt, 4'b0001);
        chk("bp_count", res_count, 2);
        step(); res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_gnt", gnt, 0);
        chk("bp_idle_valid", res_valid, 0);
        @(negedge clk);
        chk("bp_next_gnt", gnt, 4'b0010);
        step(); src_req = '0;
        wait_results(15);

        // reset at beat 10 of source 2's frame
        cfg_delay = 1; cfg_ret = 1;
        step(); src_req = '1;
        n = 0;
        while (!(m_phase == 2 && m_beats >= 10) && n < 200) begin @(negedge clk); n++; end
        chk("rst_reached", 32'(m_phase == 2 && m_owner == 2), 1);
        r0 = results_seen;
        base = frames_started;
        step();
        #1 rst_n = 1'b0;
        #1 chk_zero("midrst");
        repeat (2) @(negedge clk);
        step(); rst_n = 1'b1;
        chk("rst_no_result", results_seen, r0);
        wait_starts(base + 1);
        chk("rst_regrant", gnt_log[gnt_log.size() - 1], 4'b0001);
        step(); src_req = '0;
        wait_results(r0 + 1);
        chk("rst_res_src", hs_src, 0);
        chk("rst_res_count", hs_count, 1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
